// File: rtl/branch_issue_queue_if.sv
// Dispatch / CDB / issue bundle for branch_issue_queue.
interface branch_issue_queue_if #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned TAG_W  = 4,
   parameter int unsigned DATA_W = 16
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic              disp_valid;
   logic              disp_ready;
   logic [3:0]        disp_opcode;
   logic [TAG_W-1:0]  disp_rob;
   logic              disp_a_rdy;
   logic              disp_t_rdy;
   logic [TAG_W-1:0]  disp_a_tag;
   logic [TAG_W-1:0]  disp_t_tag;
   logic [DATA_W-1:0] disp_a_val;
   logic [DATA_W-1:0] disp_t_val;
   logic              cdb_valid;
   logic [TAG_W-1:0]  cdb_tag;
   logic [DATA_W-1:0] cdb_val;
   logic              flush;
   logic              iss_valid;
   logic [3:0]        iss_opcode;
   logic [TAG_W-1:0]  iss_rob;
   logic [DATA_W-1:0] iss_va;
   logic [DATA_W-1:0] iss_vt;
   logic [CNT_W-1:0]  count;

   modport master (
      output disp_valid, disp_opcode, disp_rob, disp_a_rdy, disp_t_rdy,
             disp_a_tag, disp_t_tag, disp_a_val, disp_t_val,
             cdb_valid, cdb_tag, cdb_val, flush,
      input  disp_ready, iss_valid, iss_opcode, iss_rob, iss_va, iss_vt, count
   );

   modport slave (
      input  disp_valid, disp_opcode, disp_rob, disp_a_rdy, disp_t_rdy,
             disp_a_tag, disp_t_tag, disp_a_val, disp_t_val,
             cdb_valid, cdb_tag, cdb_val, flush,
      output disp_ready, iss_valid, iss_opcode, iss_rob, iss_va, iss_vt, count
   );
endinterface

// File: rtl/branch_issue_queue.sv
// Age-ordered, compacted branch reservation station with CDB wakeup and oldest-ready issue.
// Optional macro BRANCH_IQ_BYPASS_EN: ready dispatch issues directly when nothing stored is ready.
module branch_issue_queue #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned TAG_W  = 4,
   parameter int unsigned DATA_W = 16
) (
   input logic                clk,
   input logic                rst_n,
   branch_issue_queue_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [3:0]        opcode;
      logic [TAG_W-1:0]  rob;
      logic              a_rdy;
      logic [TAG_W-1:0]  a_tag;
      logic [DATA_W-1:0] a_val;
      logic              t_rdy;
      logic [TAG_W-1:0]  t_tag;
      logic [DATA_W-1:0] t_val;
   } entry_t;

   entry_t            ent_q [DEPTH];
   entry_t            ent_d [DEPTH];
   entry_t            woke  [DEPTH];
   entry_t            new_e;
   entry_t            sel_e;
   logic [DEPTH-1:0]  sel_oh;
   logic              sel_found;
   logic              shift;
   logic              disp_fire;
   logic              byp;
   logic [CNT_W-1:0]  count_q, count_d, cnt_after;
   logic              iss_valid_q, iss_valid_d;
   logic [3:0]        iss_opcode_q, iss_opcode_d;
   logic [TAG_W-1:0]  iss_rob_q, iss_rob_d;
   logic [DATA_W-1:0] iss_va_q, iss_va_d;
   logic [DATA_W-1:0] iss_vt_q, iss_vt_d;

   // Capture a broadcast into any still-pending operand of an entry.
   function automatic entry_t capture(input entry_t e, input logic v,
                                      input logic [TAG_W-1:0] tag,
                                      input logic [DATA_W-1:0] val);
      entry_t r = e;
      if (v && !e.a_rdy && (e.a_tag == tag)) begin
         r.a_rdy = 1'b1;
         r.a_val = val;
      end
      if (v && !e.t_rdy && (e.t_tag == tag)) begin
         r.t_rdy = 1'b1;
         r.t_val = val;
      end
      return r;
   endfunction

   assign bus.disp_ready = (count_q != CNT_W'(DEPTH)) && !bus.flush;
   assign disp_fire      = bus.disp_valid && bus.disp_ready;

   always_comb begin
      new_e = '{opcode: bus.disp_opcode, rob: bus.disp_rob,
                a_rdy: bus.disp_a_rdy, a_tag: bus.disp_a_tag, a_val: bus.disp_a_val,
                t_rdy: bus.disp_t_rdy, t_tag: bus.disp_t_tag, t_val: bus.disp_t_val};
      new_e = capture(new_e, bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
      sel_found    = 1'b0;
      sel_e        = '0;
      sel_oh       = '0;
      iss_valid_d  = 1'b0;
      iss_opcode_d = iss_opcode_q;
      iss_rob_d    = iss_rob_q;
      iss_va_d     = iss_va_q;
      iss_vt_d     = iss_vt_q;

      // Select uses registered ready bits; wakeup results only land in next state.
      for (int unsigned i = 0; i < DEPTH; i++) begin
         woke[i] = capture(ent_q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
         if (!sel_found && (CNT_W'(i) < count_q) && ent_q[i].a_rdy && ent_q[i].t_rdy) begin
            sel_found = 1'b1;
            sel_oh[i] = 1'b1;
            sel_e     = ent_q[i];
         end
      end

`ifdef BRANCH_IQ_BYPASS_EN
      byp = disp_fire && bus.disp_a_rdy && bus.disp_t_rdy && !sel_found;
`else
      byp = 1'b0;
`endif

      for (int unsigned i = 0; i < DEPTH; i++) ent_d[i] = woke[i];
      shift = 1'b0;
      for (int unsigned i = 0; i < DEPTH - 1; i++) begin
         shift = shift | sel_oh[i];
         if (shift) ent_d[i] = woke[i+1];
      end

      cnt_after = count_q - CNT_W'(sel_found);
      if (disp_fire && !byp) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) == cnt_after) ent_d[i] = new_e;
         end
      end
      count_d = cnt_after + CNT_W'(disp_fire && !byp);

      if (sel_found) begin
         iss_valid_d  = 1'b1;
         iss_opcode_d = sel_e.opcode;
         iss_rob_d    = sel_e.rob;
         iss_va_d     = sel_e.a_val;
         iss_vt_d     = sel_e.t_val;
      end else if (byp) begin
         iss_valid_d  = 1'b1;
         iss_opcode_d = new_e.opcode;
         iss_rob_d    = new_e.rob;
         iss_va_d     = new_e.a_val;
         iss_vt_d     = new_e.t_val;
      end

      if (bus.flush) begin
         count_d     = '0;
         iss_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= '0;
         count_q      <= '0;
         iss_valid_q  <= 1'b0;
         iss_opcode_q <= '0;
         iss_rob_q    <= '0;
         iss_va_q     <= '0;
         iss_vt_q     <= '0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
         count_q      <= count_d;
         iss_valid_q  <= iss_valid_d;
         iss_opcode_q <= iss_opcode_d;
         iss_rob_q    <= iss_rob_d;
         iss_va_q     <= iss_va_d;
         iss_vt_q     <= iss_vt_d;
      end
   end

   assign bus.count      = count_q;
   assign bus.iss_valid  = iss_valid_q;
   assign bus.iss_opcode = iss_opcode_q;
   assign bus.iss_rob    = iss_rob_q;
   assign bus.iss_va     = iss_va_q;
   assign bus.iss_vt     = iss_vt_q;
endmodule

// File: tb/tb_branch_issue_queue.sv
// Directed bench for branch_issue_queue; issued ops are checked against a cycle-tagged scoreboard.
module tb_branch_issue_queue;
`ifdef BRANCH_IQ_BYPASS_EN
   localparam int BYP = 1;
`else
   localparam int BYP = 0;
`endif

   typedef struct {
      int          cyc;
      logic [39:0] f;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_fail = 0;
   int   cyc = 0;
   exp_t sb[$];

   branch_issue_queue_if bif ();
   branch_issue_queue dut (.clk(clk), .rst_n(rst_n), .bus(bif));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void expect_iss(input int at, input logic [3:0] opc, input logic [3:0] rob,
                                      input logic [15:0] va, input logic [15:0] vt);
      exp_t e;
      e.cyc = at;
      e.f   = {opc, rob, va, vt};
      sb.push_back(e);
   endfunction

   // One clock edge, then compare any issue against the scoreboard head.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      if (bif.iss_valid === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_issue", 64'(bif.iss_valid), 64'(0));
         end else begin
            e = sb.pop_front();
            check("issue_cycle", 64'(cyc), 64'(e.cyc));
            check("issue_fields", 64'({bif.iss_opcode, bif.iss_rob, bif.iss_va, bif.iss_vt}), 64'(e.f));
         end
      end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         check("missed_issue", 64'(bif.iss_valid), 64'(1));
      end
   endtask

   task automatic idle();
      bif.disp_valid = 1'b0;
      bif.cdb_valid  = 1'b0;
      bif.flush      = 1'b0;
   endtask

   task automatic disp(input logic [3:0] opc, input logic [3:0] rob,
                       input logic ar, input logic [3:0] at, input logic [15:0] av,
                       input logic tr, input logic [3:0] tt, input logic [15:0] tv);
      bif.disp_valid  = 1'b1;
      bif.disp_opcode = opc;
      bif.disp_rob    = rob;
      bif.disp_a_rdy  = ar;
      bif.disp_a_tag  = at;
      bif.disp_a_val  = av;
      bif.disp_t_rdy  = tr;
      bif.disp_t_tag  = tt;
      bif.disp_t_val  = tv;
   endtask

   task automatic cdb(input logic [3:0] tag, input logic [15:0] val);
      bif.cdb_valid = 1'b1;
      bif.cdb_tag   = tag;
      bif.cdb_val   = val;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      disp(4'h0, 4'h0, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0);
      bif.disp_valid = 1'b0;
      cdb(4'h0, 16'h0);
      bif.cdb_valid = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_count", 64'(bif.count), 64'(0));
      check("rst_iss", 64'({bif.iss_valid, bif.iss_opcode, bif.iss_rob, bif.iss_va, bif.iss_vt}), 64'(0));
      rst_n = 1'b1;
      check("rst_disp_ready", 64'(bif.disp_ready), 64'(1));

      // Ready dispatch into empty queue
      disp(4'b1000, 4'd5, 1'b1, 4'h0, 16'h0000, 1'b1, 4'h0, 16'h0040);
      expect_iss(cyc + 2 - BYP, 4'b1000, 4'd5, 16'h0000, 16'h0040);
      tick();
      idle();
      check("ready_count", 64'(bif.count), 64'(1 - BYP));
      tick();
      tick();
      check("ready_drained", 64'(bif.count), 64'(0));

      // Younger ready op overtakes older pending one; then wake the older
      disp(4'b1001, 4'd1, 1'b0, 4'd7, 16'h0, 1'b1, 4'h0, 16'h0100);
      tick();
      disp(4'b1000, 4'd2, 1'b1, 4'h0, 16'h0011, 1'b1, 4'h0, 16'h0022);
      expect_iss(cyc + 2 - BYP, 4'b1000, 4'd2, 16'h0011, 16'h0022);
      tick();
      idle();
      tick();
      tick();
      check("order_count", 64'(bif.count), 64'(1));
      cdb(4'd7, 16'h0003);
      expect_iss(cyc + 2, 4'b1001, 4'd1, 16'h0003, 16'h0100);
      tick();
      idle();
      tick();
      tick();
      check("wake_drained", 64'(bif.count), 64'(0));

      // Same-cycle capture of a pending target at dispatch
      disp(4'b1010, 4'd3, 1'b1, 4'h0, 16'h0005, 1'b0, 4'd9, 16'h0);
      cdb(4'd9, 16'h1234);
      expect_iss(cyc + 2, 4'b1010, 4'd3, 16'h0005, 16'h1234);
      tick();
      idle();
      tick();
      tick();
      check("capture_drained", 64'(bif.count), 64'(0));

      // Fill with unready entries, attempt overflow, wake the middle one
      for (int i = 0; i < 4; i++) begin
         disp(4'b1011, 4'(8 + i), 1'b0, 4'(i + 1), 16'h0, 1'b1, 4'h0, 16'(i));
         tick();
      end
      idle();
      check("full_count", 64'(bif.count), 64'(4));
      check("full_disp_ready", 64'(bif.disp_ready), 64'(0));
      disp(4'b1000, 4'd12, 1'b1, 4'h0, 16'h0077, 1'b1, 4'h0, 16'h0088);
      tick();
      idle();
      check("overflow_ignored", 64'(bif.count), 64'(4));
      tick();
      cdb(4'd3, 16'h0abc);
      expect_iss(cyc + 2, 4'b1011, 4'd10, 16'h0abc, 16'h0002);
      tick();
      idle();
      check("wake_full_count", 64'(bif.count), 64'(4));
      tick();
      check("after_issue_count", 64'(bif.count), 64'(3));
      check("after_issue_ready", 64'(bif.disp_ready), 64'(1));

      // Fourth entry becomes ready, then flush drops its issue and a dispatch
      disp(4'b1000, 4'd13, 1'b0, 4'd5, 16'h0, 1'b1, 4'h0, 16'h0013);
      tick();
      idle();
      check("refill_count", 64'(bif.count), 64'(4));
      cdb(4'd5, 16'h0055);
      tick();
      idle();
      bif.flush = 1'b1;
      disp(4'b1000, 4'd14, 1'b1, 4'h0, 16'h0001, 1'b1, 4'h0, 16'h0002);
      tick();
      idle();
      check("flush_count", 64'(bif.count), 64'(0));
      check("flush_iss_valid", 64'(bif.iss_valid), 64'(0));
      cdb(4'd1, 16'h0001);
      tick();
      idle();
      tick();
      check("flush_stays_empty", 64'(bif.count), 64'(0));

      // Issue, dispatch and wakeup in the same cycle
      disp(4'b1000, 4'd1, 1'b0, 4'd10, 16'h0, 1'b1, 4'h0, 16'h0001);
      tick();
      disp(4'b1001, 4'd2, 1'b0, 4'd11, 16'h0, 1'b1, 4'h0, 16'h0002);
      tick();
      idle();
      cdb(4'd10, 16'h00aa);
      expect_iss(cyc + 2, 4'b1000, 4'd1, 16'h00aa, 16'h0001);
      tick();
      idle();
      disp(4'b1010, 4'd3, 1'b0, 4'd12, 16'h0, 1'b1, 4'h0, 16'h0003);
      cdb(4'd11, 16'h00bb);
      expect_iss(cyc + 2, 4'b1001, 4'd2, 16'h00bb, 16'h0002);
      tick();
      idle();
      check("simul_count", 64'(bif.count), 64'(2));
      tick();
      check("simul_after", 64'(bif.count), 64'(1));
      cdb(4'd12, 16'h00cc);
      expect_iss(cyc + 2, 4'b1010, 4'd3, 16'h00cc, 16'h0003);
      tick();
      idle();
      tick();
      check("simul_drained", 64'(bif.count), 64'(0));

      // Asynchronous reset with entries queued
      for (int i = 0; i < 3; i++) begin
         disp(4'b1011, 4'(i + 1), 1'b0, 4'(i + 1), 16'h0, 1'b0, 4'(i + 1), 16'h0);
         tick();
      end
      idle();
      check("pre_reset_count", 64'(bif.count), 64'(3));
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_count", 64'(bif.count), 64'(0));
      check("async_rst_iss", 64'(bif.iss_valid), 64'(0));
      tick();
      rst_n = 1'b1;
      check("post_rst_ready", 64'(bif.disp_ready), 64'(1));
      disp(4'b1000, 4'd6, 1'b1, 4'h0, 16'h0abc, 1'b1, 4'h0, 16'h0def);
      expect_iss(cyc + 2 - BYP, 4'b1000, 4'd6, 16'h0abc, 16'h0def);
      tick();
      idle();

      // Bounded drain of anything still expected
      for (int i = 0; i < 10; i++) begin
         if (sb.size() == 0) break;
         tick();
      end
      check("scoreboard_empty", 64'(sb.size()), 64'(0));
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
